// File: rtl/sfm_pkg.sv
// Shared definitions for the SFM job launcher: register map, FSM states and
// the peripheral request bundle handed from the FSM to the initiator.
package sfm_pkg;

  localparam logic [31:0] REG_TRIGGER    = 32'h00;
  localparam logic [31:0] REG_ACQUIRE    = 32'h04;
  localparam logic [31:0] REG_SOFT_CLEAR = 32'h14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ,
    S_BACKOFF,
    S_WRITE,
    S_TRIG,
    S_WAIT_EVT,
    S_CLEAR
  } sfm_state_e;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;   // 0 = write, 1 = read
    logic [31:0] data;
  } periph_req_t;

endpackage

// File: rtl/sfm_periph_initiator.sv
// Single-outstanding peripheral initiator: holds a request until granted,
// then waits for the matching-id response. Responses with a foreign id, or
// arriving while no access is pending, are dropped.
module sfm_periph_initiator
  import sfm_pkg::*;
#(
  parameter int unsigned         ID_WIDTH = 10,
  parameter logic [ID_WIDTH-1:0] ID       = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start,
  input  periph_req_t         req,
  output logic                idle,
  output logic                gnt,
  output logic                done,
  output logic [31:0]         rdata,
  output logic                periph_req_o,
  input  logic                periph_gnt_i,
  output logic [31:0]         periph_add_o,
  output logic                periph_wen_o,
  output logic [3:0]          periph_be_o,
  output logic [31:0]         periph_data_o,
  output logic [ID_WIDTH-1:0] periph_id_o,
  input  logic [31:0]         periph_r_data_i,
  input  logic                periph_r_valid_i,
  input  logic [ID_WIDTH-1:0] periph_r_id_i
);

  typedef enum logic [1:0] {P_IDLE, P_REQ, P_RSP} phase_e;

  phase_e phase;
  logic   rsp_hit;

  assign rsp_hit = periph_r_valid_i && (periph_r_id_i == ID);

  // Phase tracking; address/data are captured once and held until the grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase         <= P_IDLE;
      periph_req_o  <= 1'b0;
      periph_add_o  <= '0;
      periph_wen_o  <= 1'b1;
      periph_data_o <= '0;
    end else begin
      case (phase)
        P_IDLE: if (start) begin
          phase         <= P_REQ;
          periph_req_o  <= 1'b1;
          periph_add_o  <= req.add;
          periph_wen_o  <= req.wen;
          periph_data_o <= req.data;
        end
        P_REQ: if (periph_gnt_i) begin
          phase        <= P_RSP;
          periph_req_o <= 1'b0;
        end
        P_RSP: if (rsp_hit) phase <= P_IDLE;
        default: phase <= P_IDLE;
      endcase
    end
  end

  assign idle        = (phase == P_IDLE);
  assign gnt         = (phase == P_REQ) && periph_gnt_i;
  assign done        = (phase == P_RSP) && rsp_hit;
  assign rdata       = periph_r_data_i;
  assign periph_be_o = 4'hf;
  assign periph_id_o = ID;

endmodule

// File: rtl/sfm_job_launcher.sv
// Job launcher: acquires an accelerator job slot (with backoff while busy),
// streams register writes from the command port, triggers the job and waits
// for the end-of-job event, soft-clearing the accelerator on timeout.
module sfm_job_launcher
  import sfm_pkg::*;
#(
  parameter logic [31:0]         BASE_ADDR  = 32'h1c100000,
  parameter int unsigned         ID_WIDTH   = 10,
  parameter logic [ID_WIDTH-1:0] ID         = '0,
  parameter logic [31:0]         REG_OFFSET = 32'h40,
  parameter int unsigned         IDX_W      = 5,
  parameter int unsigned         BACKOFF    = 16,
  parameter int unsigned         TIMEOUT    = 2**20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [IDX_W-1:0]    cmd_idx_i,
  input  logic [31:0]         cmd_data_i,
  input  logic                cmd_last_i,
  output logic                periph_req_o,
  input  logic                periph_gnt_i,
  output logic [31:0]         periph_add_o,
  output logic                periph_wen_o,
  output logic [3:0]          periph_be_o,
  output logic [31:0]         periph_data_o,
  output logic [ID_WIDTH-1:0] periph_id_o,
  input  logic [31:0]         periph_r_data_i,
  input  logic                periph_r_valid_i,
  input  logic [ID_WIDTH-1:0] periph_r_id_i,
  input  logic                evt_i,
  output logic                busy_o,
  output logic                job_done_o,
  output logic                job_err_o,
  output logic [7:0]          job_id_o
);

  localparam int unsigned BO_W  = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  sfm_state_e       state;
  logic             last_q;
  logic [BO_W-1:0]  bo_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic             ini_start;
  logic             ini_idle;
  logic             ini_gnt;
  logic             ini_done;
  logic [31:0]      ini_rdata;
  periph_req_t      ini_req;
  logic             unused_rdata;

  assign unused_rdata = ^ini_rdata[30:8];

  // Each access state launches exactly one access: the initiator stays
  // non-idle until its response, and the FSM leaves (or, in WRITE, waits for
  // the next command) on that same response.
  always_comb begin
    ini_start = 1'b0;
    ini_req   = '0;
    case (state)
      S_ACQ: begin
        ini_start   = ini_idle;
        ini_req.add = BASE_ADDR + REG_ACQUIRE;
        ini_req.wen = 1'b1;
      end
      S_WRITE: begin
        ini_start    = ini_idle && cmd_valid_i;
        ini_req.add  = BASE_ADDR + REG_OFFSET + (32'(cmd_idx_i) << 2);
        ini_req.data = cmd_data_i;
      end
      S_TRIG: begin
        ini_start   = ini_idle;
        ini_req.add = BASE_ADDR + REG_TRIGGER;
      end
      S_CLEAR: begin
        ini_start   = ini_idle;
        ini_req.add = BASE_ADDR + REG_SOFT_CLEAR;
      end
      default: ;
    endcase
  end

  // The command is consumed on the grant of the write that carries it.
  assign cmd_ready_o = (state == S_WRITE) && ini_gnt;
  assign busy_o      = (state != S_IDLE);

  // Job sequencing FSM with registered status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      last_q     <= 1'b0;
      bo_cnt     <= '0;
      tmo_cnt    <= '0;
      job_id_o   <= '0;
      job_done_o <= 1'b0;
      job_err_o  <= 1'b0;
    end else begin
      job_done_o <= 1'b0;
      job_err_o  <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid_i) state <= S_ACQ;
        S_ACQ: if (ini_done) begin
          if (ini_rdata[31]) begin
            state  <= S_BACKOFF;
            bo_cnt <= '0;
          end else begin
            job_id_o <= ini_rdata[7:0];
            state    <= S_WRITE;
          end
        end
        S_BACKOFF: begin
          if (bo_cnt == BO_W'(BACKOFF - 1)) begin
            bo_cnt <= '0;
            state  <= S_ACQ;
          end else begin
            bo_cnt <= bo_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (ini_gnt) last_q <= cmd_last_i;
          if (ini_done && last_q) state <= S_TRIG;
        end
        S_TRIG: if (ini_done) begin
          state   <= S_WAIT_EVT;
          tmo_cnt <= '0;
        end
        S_WAIT_EVT: begin
          // The event takes priority over a timeout landing in the same cycle.
          if (evt_i) begin
            job_done_o <= 1'b1;
            state      <= S_IDLE;
          end else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
            state <= S_CLEAR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_CLEAR: if (ini_done) begin
          job_err_o <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sfm_periph_initiator #(
    .ID_WIDTH (ID_WIDTH),
    .ID       (ID)
  ) u_ini (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start            (ini_start),
    .req              (ini_req),
    .idle             (ini_idle),
    .gnt              (ini_gnt),
    .done             (ini_done),
    .rdata            (ini_rdata),
    .periph_req_o     (periph_req_o),
    .periph_gnt_i     (periph_gnt_i),
    .periph_add_o     (periph_add_o),
    .periph_wen_o     (periph_wen_o),
    .periph_be_o      (periph_be_o),
    .periph_data_o    (periph_data_o),
    .periph_id_o      (periph_id_o),
    .periph_r_data_i  (periph_r_data_i),
    .periph_r_valid_i (periph_r_valid_i),
    .periph_r_id_i    (periph_r_id_i)
  );

endmodule
